sha256d_hash_core: RTL and testbench
====================================

Name: sha256d_hash_core

Overview:
- Iterative double-SHA-256 engine for the Bitcoin mining datapath. One round per clock.
- An external sequencer drives `block` and `select` and streams 32-bit message words on `msg_in`.
- The core hashes the 80-byte header, already padded to two 512-bit blocks (block 0 and block 1), then re-hashes the 256-bit result internally (block 2).
- The final digest appears on h1..h8.

Parameters:
- None. All widths are fixed by SHA-256.

Ports:
- `clk` — input, 1 — rising-edge clock.
- `rst_n` — input, 1 — synchronous active-low reset.
- `block` — input, 2 — phase: 0 = header block 0, 1 = header block 1, 2 = second SHA pass, 3 = idle.
- `select` — input, 7 — cycle index within a phase, 0..64.
- `msg_in` — input, 32 — message word W[select] for select 0..15 in phases 0/1; big-endian SHA word.
- `h1`..`h8` — output, 32 each — final digest words H0..H7; h1 = H0.

Behaviour:
- **Sequencer contract.** `select` counts 0..64 (65 cycles per phase); `block` advances 0→1→2→3→0. Inputs are sampled on the rising edge.
- **Reset** (`rst_n` = 0 at a rising edge):
  - h1..h8, the working vars a..h, the schedule window, the mid-state and the first-pass digest all clear to 0.
  - Reset overrides any operation in flight, with no partial result.
- **Chaining value (CV) per phase:**
  - block 0 → SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - block 1 → mid-state saved from block 0.
  - block 2 → IV.
- **Round t = select, for select 0..63, in phases 0..2:**
  - At select = 0 the round inputs are CV (combinational load, not a prior register).
  - W[t] source:
    - t < 16, phases 0/1: `msg_in`.
    - t < 16, phase 2: internal padded block. W0..W7 = first-pass digest; W8 = 80000000; W9..W14 = 0; W15 = 00000100.
    - t ≥ 16: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], from a 16-entry shift window.
  - All additions are mod 2^32. K[t] is the standard constant.
- **Finalisation fused with round 63** (the edge with select = 63): new H = CV + round-63 result, word-wise mod 2^32.
  - Phase 0: store as the mid-state.
  - Phase 1: store as the first-pass digest.
  - Phase 2: write to h1..h8.
- **Idle and ignore rules:**
  - select = 64: idle cycle; no state change.
  - block 3: idle; all state holds.
  - `msg_in` is ignored in phases 2 and 3 and for select 16..64.
- **Output timing:**
  - h1..h8 change only on the phase-2, select-63 edge (or on reset).
  - The outputs are stable for the whole select = 64 cycle of phase 2, through phase 3 and phases 0/1 of the next iteration, until the next phase-2 finalisation.
- **Undefined inputs:** select values > 64 are treated like 64 (no state change).
- **Latency:** 3 × 65 = 195 cycles from block 0 / select 0 to a valid digest. A new iteration may start immediately after phase 3.

Decomposition:
- Package `sha256_pkg`:
  - `K[0:63]` constant array, IV constants, second-pass padding constants.
  - Functions: Σ0, Σ1, σ0, σ1, Ch, Maj.
  - Typedef for the 8×32 state.
- One natural sub-module: `sha256_round`, a combinational single round taking (a..h, W, K) and returning next a..h.
- Schedule window, phase control and the digest registers stay in the top module.

Test Plan:
- **Reset:** hold `rst_n` = 0 for 3 cycles → h1..h8 = 00000000. Then run the sequencer with `rst_n` = 1; h1..h8 remain 0 until phase-2 select 63.
- **Genesis header:**
  - Stimulus: words 01000000, 8×00000000, 3ba3edfd 7a7b12b2 7ac72c3e 67768f61 7fc81bc3 888a5132 3a9fb8aa 4b1e5e4a, 29ab5f49 ffff001d 1dac2b7c, then 80000000, 10×00000000, 00000280.
  - Required h1..h8 = 6fe28c0a b6f1b372 c1a6a246 ae63f74f 931e8365 e15a089c 68d61900 00000000.
  - Valid at the edge after phase-2 select 63.
- **Hold:** after the genesis digest, drive block 3, then block 0/1 of a new header → h1..h8 unchanged until the next phase-2 select 63.
- **msg_in ignored:** randomise `msg_in` during phase 2 and during select ≥ 16 of the genesis run → same digest as above.
- **Back-to-back:** two consecutive iterations, nonce word 1dac2b7c then 1dac2b7d → first digest equals the genesis value; second digest differs and matches the software model.
- **Reset mid-operation:** assert `rst_n` at phase 1 / select 30, then restart at block 0 → outputs 0 after reset. The subsequent full run gives the correct genesis digest with no residue from the aborted run.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions for the double-SHA mining core.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [0:7][31:0] state_t;  // index 0 = a / H0

  typedef enum logic [1:0] {
    PH_BLK0  = 2'd0,
    PH_BLK1  = 2'd1,
    PH_PASS2 = 2'd2,
    PH_IDLE  = 2'd3
  } phase_e;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padding of the 256-bit first-pass digest into a single 512-bit block.
  localparam word_t PAD_W8  = 32'h80000000;
  localparam word_t PAD_W15 = 32'h00000100;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic state_t state_add(input state_t x, input state_t y);
    state_t r;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[i] + y[i];
    end
    return r;
  endfunction

  // Message word idx (0..15) of the padded second-pass block.
  function automatic word_t pad_word(input state_t dig, input logic [3:0] idx);
    word_t r;
    case (idx)
      4'd8:    r = PAD_W8;
      4'd15:   r = PAD_W15;
      default: begin
        if (idx < 4'd8) begin
          r = dig[idx[2:0]];
        end else begin
          r = 32'h00000000;
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t state_i,
  input  word_t  w_i,
  input  word_t  k_i,
  output state_t state_o
);

  word_t t1_s;
  word_t t2_s;

  // One round: new a/e from T1/T2, remaining words shift down.
  always_comb begin
    t1_s = state_i[7] + big_sigma1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
    t2_s = big_sigma0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);
    state_o    = state_i;
    state_o[0] = t1_s + t2_s;
    state_o[1] = state_i[0];
    state_o[2] = state_i[1];
    state_o[3] = state_i[2];
    state_o[4] = state_i[3] + t1_s;
    state_o[5] = state_i[4];
    state_o[6] = state_i[5];
    state_o[7] = state_i[6];
  end

endmodule

// File: rtl/sha256d_hash_core.sv
// Iterative double-SHA-256 core: one round per clock over three externally sequenced phases.
module sha256d_hash_core
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  block,
  input  logic [6:0]  select,
  input  logic [31:0] msg_in,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h4,
  output logic [31:0] h5,
  output logic [31:0] h6,
  output logic [31:0] h7,
  output logic [31:0] h8
);

  state_t            work_q, work_d;
  state_t            mid_q, mid_d;
  state_t            dig1_q, dig1_d;
  state_t            hout_q, hout_d;
  logic [0:15][31:0] win_q, win_d;  // win_q[15] = W[t-1], win_q[0] = W[t-16]

  phase_e     phase_s;
  logic [5:0] t_s;
  logic       active_s;
  logic       final_s;
  state_t     cv_s;
  state_t     rin_s;
  state_t     rout_s;
  state_t     fin_s;
  word_t      w_s;
  word_t      k_s;

  // Phase decode, chaining value and round operand selection.
  always_comb begin
    phase_s  = phase_e'(block);
    t_s      = select[5:0];
    active_s = (phase_s != PH_IDLE) && (select < 7'd64);
    final_s  = active_s && (select == 7'd63);

    case (phase_s)
      PH_BLK1: cv_s = mid_q;
      default: cv_s = IV;
    endcase

    if (select == 7'd0) begin
      rin_s = cv_s;
    end else begin
      rin_s = work_q;
    end

    k_s = K[t_s];

    if (select < 7'd16) begin
      if (phase_s == PH_PASS2) begin
        w_s = pad_word(dig1_q, t_s[3:0]);
      end else begin
        w_s = msg_in;
      end
    end else begin
      w_s = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
    end
  end

  sha256_round u_round (
    .state_i (rin_s),
    .w_i     (w_s),
    .k_i     (k_s),
    .state_o (rout_s)
  );

  // Next state: advance one round; fold the CV back in on round 63.
  always_comb begin
    fin_s  = state_add(cv_s, rout_s);
    work_d = work_q;
    mid_d  = mid_q;
    dig1_d = dig1_q;
    hout_d = hout_q;
    win_d  = win_q;
    if (active_s) begin
      work_d = rout_s;
      win_d  = {win_q[1:15], w_s};
      if (final_s) begin
        case (phase_s)
          PH_BLK0:  mid_d  = fin_s;
          PH_BLK1:  dig1_d = fin_s;
          PH_PASS2: hout_d = fin_s;
          default:  hout_d = hout_q;
        endcase
      end else begin
        hout_d = hout_q;
      end
    end else begin
      work_d = work_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      mid_q  <= '0;
      dig1_q <= '0;
      hout_q <= '0;
      win_q  <= '0;
    end else begin
      work_q <= work_d;
      mid_q  <= mid_d;
      dig1_q <= dig1_d;
      hout_q <= hout_d;
      win_q  <= win_d;
    end
  end

  assign h1 = hout_q[0];
  assign h2 = hout_q[1];
  assign h3 = hout_q[2];
  assign h4 = hout_q[3];
  assign h5 = hout_q[4];
  assign h6 = hout_q[5];
  assign h7 = hout_q[6];
  assign h8 = hout_q[7];

endmodule

// File: tb/tb_sha256d_hash_core.sv
// Randomised bench for sha256d_hash_core against a plain software double-SHA-256 model.
module tb_sha256d_hash_core;

  logic        clk;
  logic        rst_n;
  logic [1:0]  blk;
  logic [6:0]  sel;
  logic [31:0] msg;
  logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8;

  int n_checks;
  int n_pass;

  localparam logic [255:0] GENESIS =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] REF_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] NONCE0 = 32'h1dac2b7c;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256d_hash_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .block  (blk),
    .select (sel),
    .msg_in (msg),
    .h1     (h1),
    .h2     (h2),
    .h3     (h3),
    .h4     (h4),
    .h5     (h5),
    .h6     (h6),
    .h7     (h7),
    .h8     (h8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] dut_h();
    return {h1, h2, h3, h4, h5, h6, h7, h8};
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] cv, input logic [511:0] blk512);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk512[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = cv[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = cv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Genesis-style 80-byte header with a chosen nonce, padded to 1024 bits.
  function automatic logic [1023:0] header(input logic [31:0] nonce);
    return {32'h01000000, 256'h0,
            256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
            32'h29ab5f49, 32'hffff001d, nonce, 32'h80000000, 320'h0, 32'h00000280};
  endfunction

  function automatic logic [255:0] ref_sha256d(input logic [31:0] nonce);
    logic [1023:0] hd;
    logic [255:0]  d1;
    hd = header(nonce);
    d1 = ref_compress(ref_compress(REF_IV, hd[1023:512]), hd[511:0]);
    return ref_compress(REF_IV, {d1, 32'h80000000, 192'h0, 32'h00000100});
  endfunction

  task automatic step(input logic r, input logic [1:0] b, input logic [6:0] s, input logic [31:0] m);
    @(negedge clk);
    rst_n = r;
    blk   = b;
    sel   = s;
    msg   = m;
    @(posedge clk);
    #1;
  endtask

  // One full 4x65-cycle iteration; checks hold of prev before, and exp after, finalisation.
  task automatic run_iter(input string tag, input logic [31:0] nonce, input bit junk,
                          input logic [255:0] prev, input logic [255:0] exp);
    logic [1023:0] hd;
    logic [31:0]   mv;
    hd = header(nonce);
    for (int ph = 0; ph < 4; ph++) begin
      for (int s = 0; s < 65; s++) begin
        if (ph < 2 && s < 16) mv = hd[1023 - 32*(ph*16 + s) -: 32];
        else if (junk) mv = $urandom;
        else mv = 32'h0;
        step(1'b1, 2'(ph), 7'(s), mv);
        if (ph == 2 && s == 63) check({tag, "_digest"}, dut_h(), exp);
        else if (ph == 2 && s == 62) check({tag, "_pre63"}, dut_h(), prev);
        else if (ph == 2 && s == 64) check({tag, "_sel64"}, dut_h(), exp);
        else if (ph == 3 && s == 64) check({tag, "_idle"}, dut_h(), exp);
        else if (ph < 2 && s == 64) check({tag, "_hold"}, dut_h(), prev);
      end
    end
  endtask

  initial begin
    logic [255:0] exp2;
    logic [1023:0] hd;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; blk = 2'd3; sel = 7'd64; msg = 32'h0;

    for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 7'd64, $urandom);
    check("reset", dut_h(), 256'h0);

    run_iter("genesis", NONCE0, 1'b0, 256'h0, GENESIS);
    run_iter("junk", NONCE0, 1'b1, GENESIS, GENESIS);

    exp2 = ref_sha256d(NONCE0 + 32'h1);
    run_iter("b2b_a", NONCE0, 1'b1, GENESIS, GENESIS);
    run_iter("b2b_b", NONCE0 + 32'h1, 1'b1, GENESIS, exp2);
    check("b2b_differs", {255'h0, dut_h() != GENESIS}, 256'h1);

    // Abort a run at phase 1 / select 30 with reset.
    hd = header(32'hdeadbeef);
    for (int i = 0; i < 96; i++) begin
      if (i < 65) step(1'b1, 2'd0, 7'(i), (i < 16) ? hd[1023 - 32*i -: 32] : $urandom);
      else step(1'b1, 2'd1, 7'(i - 65), (i < 81) ? hd[511 - 32*(i-65) -: 32] : $urandom);
    end
    check("pre_abort_hold", dut_h(), exp2);
    step(1'b0, 2'd1, 7'd30, $urandom);
    step(1'b0, 2'd1, 7'd31, $urandom);
    check("abort_reset", dut_h(), 256'h0);
    run_iter("after_abort", NONCE0, 1'b1, 256'h0, GENESIS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
